// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and types for the pooled-feature flatten buffer.
package cnn_pkg;
  localparam int DATA_W = 16;
  localparam int CHANNELS = 4;
  localparam int POOL_DIM = 7;
  localparam int N = POOL_DIM * POOL_DIM;
  localparam int TOTAL = CHANNELS * N;
  localparam logic [5:0] PIX_N = 6'(N);
  localparam logic [5:0] PIX_LAST = 6'(N - 1);
  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef enum logic {FILL, DRAIN} flatten_state_t;
endpackage

// File: rtl/flatten_chan_mem.sv
// flatten_chan_mem: one channel's 49-word simple dual-port store with registered read.
module flatten_chan_mem
  import cnn_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [5:0] waddr,
  input  pixel_t     wdata,
  input  logic       re,
  input  logic [5:0] raddr,
  output pixel_t     rdata
);
  pixel_t mem [N];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/pool_flatten_buffer.sv
// pool_flatten_buffer: captures four 7x7 pooled maps, then streams them channel-major
// over valid/ready; single-buffered, so it alternates between FILL and DRAIN.
module pool_flatten_buffer
  import cnn_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  pixel_t              pixel_in [0:CHANNELS-1],
  input  logic [CHANNELS-1:0] valid_in,
  output pixel_t              data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                data_last,
  output logic [1:0]          chan_idx,
  output logic [5:0]          pix_idx,
  output logic                busy,
  output logic                overflow
);
  flatten_state_t state;
  logic [5:0] wcnt [CHANNELS];
  logic [1:0] rc;
  logic [5:0] rp;
  pixel_t rdata [CHANNELS];
  logic [CHANNELS-1:0] full, we, drop;
  logic load, fire_last;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign full[g] = wcnt[g] == PIX_N;
    assign we[g] = state == FILL && valid_in[g] && !full[g];
    assign drop[g] = valid_in[g] && (state == DRAIN || full[g]);
    flatten_chan_mem u_mem (
      .clk(clk), .reset(reset), .we(we[g]), .waddr(wcnt[g]), .wdata(pixel_in[g]),
      .re(load && rc == 2'(g)), .raddr(rp), .rdata(rdata[g])
    );
  end
  // The read pointer always names the next word to load into the output stage.
  assign load = state == DRAIN && (!data_valid || (data_ready && !data_last));
  assign fire_last = state == DRAIN && data_valid && data_ready && data_last;
  assign data_out = rdata[chan_idx];
  assign busy = state == DRAIN;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FILL;
      for (int c = 0; c < CHANNELS; c++) wcnt[c] <= '0;
      rc <= '0;
      rp <= '0;
      data_valid <= 1'b0;
      data_last <= 1'b0;
      chan_idx <= '0;
      pix_idx <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
      for (int c = 0; c < CHANNELS; c++) if (we[c]) wcnt[c] <= wcnt[c] + 6'd1;
      if (state == FILL && &full) state <= DRAIN;
      if (load) begin
        data_valid <= 1'b1;
        chan_idx <= rc;
        pix_idx <= rp;
        data_last <= rc == 2'(CHANNELS - 1) && rp == PIX_LAST;
        rp <= rp == PIX_LAST ? 6'd0 : rp + 6'd1;
        rc <= rp == PIX_LAST ? rc + 2'd1 : rc;
      end else if (fire_last) begin
        state <= FILL;
        data_valid <= 1'b0;
        data_last <= 1'b0;
        rc <= '0;
        rp <= '0;
        for (int c = 0; c < CHANNELS; c++) wcnt[c] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pool_flatten_buffer.sv
// tb_pool_flatten_buffer: scenario table plus hand sequences, checked against
// per-channel queues holding the first 49 accepted pixels of each channel.
module tb_pool_flatten_buffer;
  logic clk = 0;
  logic reset = 0;
  logic signed [15:0] px [0:3];
  logic [3:0] vin = '0;
  logic signed [15:0] dout;
  logic dvalid, dready = 0, dlast, busy, ovf;
  logic [1:0] cidx;
  logic [5:0] pidx;
  always #5 clk = ~clk;
  pool_flatten_buffer dut (
    .clk(clk), .reset(reset), .pixel_in(px), .valid_in(vin), .data_out(dout),
    .data_valid(dvalid), .data_ready(dready), .data_last(dlast), .chan_idx(cidx),
    .pix_idx(pidx), .busy(busy), .overflow(ovf)
  );
  int checks = 0;
  int errors = 0;
  logic signed [15:0] q [4][$];
  typedef struct {int skew3; int rv; int rd; int rmode; int drop_at; int exp_ovf;} vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic apply(input logic [3:0] v, input logic signed [15:0] p [4]);
    vin = v;
    px = p;
    for (int c = 0; c < 4; c++)
      if (v[c] && q[c].size() < 49) q[c].push_back(p[c]);
    tick();
    vin = '0;
  endtask
  task automatic do_reset();
    reset = 0;
    vin = '0;
    dready = 0;
    tick();
    chk("rst_data_out", dout, 0);
    chk("rst_valid", dvalid, 0);
    chk("rst_last", dlast, 0);
    chk("rst_chan", cidx, 0);
    chk("rst_pix", pidx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", ovf, 0);
    reset = 1;
    for (int c = 0; c < 4; c++) q[c].delete();
  endtask
  function automatic bit all_full();
    return q[0].size() == 49 && q[1].size() == 49 && q[2].size() == 49 && q[3].size() == 49;
  endfunction
  task automatic fill(input int skew3, input int rv, input int rd);
    logic [3:0] v;
    logic signed [15:0] p [4];
    int cyc = 0;
    while (!all_full() && cyc < 2000) begin
      chk("fill_busy", busy, 0);
      for (int c = 0; c < 4; c++) begin
        v[c] = q[c].size() < 49 && (c != 3 || cyc >= skew3) && (rv == 0 || $urandom_range(1) == 1);
        if (rd == 0) p[c] = 16'(c * 100 + q[c].size());
        else if (rd == 1) p[c] = 16'($urandom);
        else p[c] = -16'sd1;
      end
      apply(v, p);
      cyc++;
    end
    chk("fill_done", all_full(), 1);
    chk("busy_after_last_write", busy, 0);
    tick();
    chk("busy_enter_drain", busy, 1);
    chk("valid_enter_drain", dvalid, 0);
    tick();
    chk("valid_one_later", dvalid, 1);
  endtask
  task automatic drain(input int rmode, input int drop_at, input int stop_at);
    logic signed [15:0] p [4];
    int idx = 0;
    int n = 0;
    bit dropped = 0;
    bit rdy;
    p[0] = -16'sd5; p[1] = 0; p[2] = 0; p[3] = 0;
    while (idx < 196 && idx != stop_at && n < 3000) begin
      chk("valid_mid", dvalid, 1);
      chk("data", dout, q[idx / 49][idx % 49]);
      chk("chan_idx", cidx, idx / 49);
      chk("pix_idx", pidx, idx % 49);
      chk("last", dlast, idx == 195);
      rdy = rmode == 0 ? 1'b1 : rmode == 1 ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom_range(1));
      dready = rdy;
      if (idx == drop_at && !dropped) begin
        dropped = 1;
        apply(4'b0001, p);
      end else apply(4'b0000, p);
      if (rdy) idx++;
      n++;
    end
    dready = 0;
    chk("drain_in_budget", n < 3000, 1);
    if (idx == 196) begin
      if (rmode == 0) chk("no_bubbles", n, 196);
      chk("end_valid", dvalid, 0);
      chk("end_last", dlast, 0);
      chk("end_busy", busy, 0);
      for (int c = 0; c < 4; c++) q[c].delete();
    end
  endtask
  initial begin
    logic signed [15:0] p [4];
    tbl[0] = '{skew3: 0,  rv: 0, rd: 0, rmode: 0, drop_at: -1, exp_ovf: 0};
    tbl[1] = '{skew3: 20, rv: 0, rd: 0, rmode: 0, drop_at: -1, exp_ovf: 0};
    tbl[2] = '{skew3: 0,  rv: 0, rd: 0, rmode: 1, drop_at: -1, exp_ovf: 0};
    tbl[3] = '{skew3: 0,  rv: 0, rd: 0, rmode: 0, drop_at: 60, exp_ovf: 1};
    tbl[4] = '{skew3: 5,  rv: 1, rd: 1, rmode: 2, drop_at: -1, exp_ovf: 0};
    for (int c = 0; c < 4; c++) px[c] = '0;
    for (int i = 0; i < 5; i++) begin
      do_reset();
      fill(tbl[i].skew3, tbl[i].rv, tbl[i].rd);
      drain(tbl[i].rmode, tbl[i].drop_at, -1);
      chk("overflow_table", ovf, tbl[i].exp_ovf);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) p[c] = 16'(c * 100 + k);
      apply(4'b1111, p);
    end
    for (int k = 10; k < 50; k++) begin
      p[0] = 16'(k);
      apply(4'b0001, p);
      if (k == 48) chk("ovf_before_50th", ovf, 0);
    end
    chk("ovf_after_50th", ovf, 1);
    fill(0, 0, 0);
    drain(0, -1, -1);
    chk("ovf_sticky", ovf, 1);
    do_reset();
    fill(0, 0, 0);
    drain(0, -1, 100);
    do_reset();
    fill(0, 0, 2);
    drain(0, -1, -1);
    chk("ovf_after_refill", ovf, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_flatten_buffer.md
Name: pool_flatten_buffer

Overview:
- Sits directly downstream of the 4-channel 14x14 max-pooling stage.
- Captures the four 7x7 pooled feature maps, 196 signed 16-bit words in total, into on-chip storage.
- Once all four maps are complete, streams them out flattened in channel-major order over a valid/ready handshake to the fully-connected layer.
- Single-buffered: it is either filling or draining, never both.

Parameters:
CHANNELS, 4, number of pooled channels
POOL_DIM, 7, pooled map width/height; words per channel N = POOL_DIM*POOL_DIM = 49
DATA_W, 16, signed pixel width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
pixel_in  in  CHANNELS x DATA_W (signed, unpacked [0:CHANNELS-1])  pooled pixel per channel
valid_in  in  CHANNELS  per-channel pixel strobe; bit c qualifies pixel_in[c]
data_out  out  DATA_W (signed)  flattened output word
data_valid  out  1  data_out valid
data_ready  in  1  downstream accepts word when data_valid && data_ready
data_last  out  1  high with the final (196th) word
chan_idx  out  2  channel of the current data_out word
pix_idx  out  6  pixel index 0..48 of the current data_out word
busy  out  1  high while in DRAIN
overflow  out  1  sticky; a pixel was dropped

Behaviour:
- One clock domain. Reset is sampled on clk only and is active when reset==0.
- Reset values: data_out=0, data_valid=0, data_last=0, chan_idx=0, pix_idx=0, busy=0, overflow=0, state=FILL, all write counters=0, read pointer=0.
- Storage contents are not reset.
- FILL state:
  - Each channel c has its own write counter wcnt[c] (0..N).
  - When valid_in[c]==1 and wcnt[c]<N: write mem[c][wcnt[c]]=pixel_in[c], then wcnt[c]++.
  - Channels are independent; any subset of valid_in bits may be high in a cycle.
  - If valid_in[c]==1 and wcnt[c]==N: the pixel is dropped and overflow is set.
  - FILL -> DRAIN on the clock edge after every wcnt[c]==N, including the case where the final writes of several channels land in the same cycle.
- DRAIN state:
  - busy=1.
  - Read order is c0 p0..p48, then c1 p0..p48, then c2, then c3.
  - The read pointer has a channel part and a pixel part. The pixel part wraps 48->0 and the channel part increments at the wrap.
  - Output register is loaded from storage with 1-cycle latency: data_valid rises exactly 1 cycle after entering DRAIN, presenting c0 p0.
  - While data_valid && !data_ready: data_out, chan_idx, pix_idx and data_last are held stable.
  - On a handshake, the next word appears the following cycle. With data_ready held high the throughput is 1 word/cycle, with no bubbles.
  - data_last=1 only with c3 p48.
  - Handshake on the last word: on the next edge, data_valid=0, data_last=0, busy=0, write counters and read pointer are cleared, and state returns to FILL.
- Any valid_in bit high while in DRAIN, including the cycle of the final handshake: the pixel is dropped and overflow is set.
- overflow stays set until reset.
- Reset asserted mid-FILL or mid-DRAIN: the partial frame is abandoned and all reset values apply on the next edge.
- No arithmetic. Data passes bit-exact, sign preserved.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W, CHANNELS, POOL_DIM constants and derived N=49, TOTAL=196.
  - typedef pixel_t (logic signed [DATA_W-1:0]).
  - enum flatten_state_t {FILL, DRAIN}.
- One natural sub-module: flatten_chan_mem, a per-channel 49x16 simple dual-port RAM with a write-counter input and registered read.
  - Instantiate it CHANNELS times.
  - The top mux-selects the read data by chan_idx.

Test Plan:
- Lockstep fill: all valid_in=4'b1111 for 49 cycles, pixel_in[c]=c*100+k, data_ready=1. Required: busy rises at cycle 50, data_valid rises 1 cycle later, then 196 consecutive words 0,1,..48,100..148,200..248,300..348, with data_last only on 348.
- Skewed channels: channel 3 delayed 20 cycles vs. the others. Required: no DRAIN until ch3's 49th write; the output order and values are identical to the lockstep case.
- Backpressure: toggle data_ready 1,0,0,1 pattern during drain. Required: data_out and indices are held while ready is low, no word is lost or duplicated, 196 handshakes total, and busy=0 after the last one.
- Overflow: valid_in[0] pulsed 50 times while the other channels are at 10. Required: the 50th pixel is dropped, overflow=1 and stays set, and ch0 still outputs its first 49 values.
- DRAIN input drop: assert valid_in=4'b0001 with value -5 at word 60 of the drain. Required: the output stream is unchanged and overflow=1.
- Reset mid-drain: drive reset=0 at word 100 for 1 cycle. Required: all outputs return to their reset values the next cycle. A new 49-cycle fill followed by a drain with values -1 (0xFFFF) reproduces 196 words of -1.
